mmio_periph_hub: RTL and testbench

- Parametrised memory-mapped peripheral block for the RV32I core; replaces the ad-hoc UART-store decode and the single free-running hardware counter.
- Provides a buffered 8N1 UART transmitter with status and backpressure visibility, a 64-bit cycle counter and a 64-bit instructions-retired counter.
- The core drives it from the load/store address and data paths.
- Read data is combinational so single-cycle load timing is preserved.

---
 rtl/mmio_periph_hub.sv | 208 ++++++++++++++++++++
 tb/tb_mmio_periph_hub.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_periph_hub.sv
// Memory-mapped peripheral hub for the RV32I core: buffered 8N1 UART transmitter,
// 64-bit cycle counter and 64-bit instructions-retired counter with coherent HI reads.
module mmio_periph_hub #(
    parameter logic [31:0] BASE_ADDR  = 32'hf600_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          BAUD_DIV   = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retire,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        uart_tx
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Register window decode: six word registers, word-aligned only.
    logic [31:0] offset;
    logic        mapped;
    logic [2:0]  reg_idx;

    assign offset  = addr - BASE_ADDR;
    assign mapped  = (offset < 32'd24) && (offset[1:0] == 2'b00);
    assign reg_idx = offset[4:2];
    assign hit     = mapped;

    logic wr_txdata, wr_status, rd_cyc_lo, rd_ir_lo;
    assign wr_txdata = we && mapped && (reg_idx == 3'd0);
    assign wr_status = we && mapped && (reg_idx == 3'd1);
    assign rd_cyc_lo = re && mapped && (reg_idx == 3'd2);
    assign rd_ir_lo  = re && mapped && (reg_idx == 3'd4);

    logic unused_wdata_bits;
    assign unused_wdata_bits = ^wdata[31:8];

    // TX FIFO storage and bookkeeping
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full;
    logic          pop, push_ok;
    logic          overflow;

    tx_state_t     state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          baud_end;
    logic          tx_busy;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign tx_busy  = (state != IDLE);

    // The FSM dequeues when idle, or at the last STOP cycle for a gapless next frame.
    assign pop     = !empty && ((state == IDLE) || ((state == STOP) && baud_end));
    assign push_ok = wr_txdata && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped byte in the same cycle as a clear keeps the flag set.
            if (wr_txdata && !push_ok) begin
                overflow <= 1'b1;
            end else if (wr_status && wdata[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx  <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift_reg <= fifo_mem[rd_ptr];
                        uart_tx   <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        uart_tx   <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= '0;
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            uart_tx   <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg <= fifo_mem[rd_ptr];
                            uart_tx   <= 1'b0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    // Counters; a LO read snapshots the HI word so LO-then-HI pairs stay coherent.
    logic [63:0] cyc_cnt, ir_cnt;
    logic [31:0] cyc_hi_shadow, ir_hi_shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt       <= '0;
            ir_cnt        <= '0;
            cyc_hi_shadow <= '0;
            ir_hi_shadow  <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 64'd1;
            if (inst_retire) ir_cnt        <= ir_cnt + 64'd1;
            if (rd_cyc_lo)   cyc_hi_shadow <= cyc_cnt[63:32];
            if (rd_ir_lo)    ir_hi_shadow  <= ir_cnt[63:32];
        end
    end

    logic [7:0]  count8;
    logic [31:0] status_word;
    assign count8      = 8'(count);
    assign status_word = {16'b0, count8, 4'b0, overflow, tx_busy, full, empty};

    always_comb begin
        rdata = '0;
        if (mapped) begin
            case (reg_idx)
                3'd1:    rdata = status_word;
                3'd2:    rdata = cyc_cnt[31:0];
                3'd3:    rdata = cyc_hi_shadow;
                3'd4:    rdata = ir_cnt[31:0];
                3'd5:    rdata = ir_hi_shadow;
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_periph_hub.sv
// Directed + randomized bench for mmio_periph_hub with a frame-decoding UART monitor
// and clock/instret reference counts.
module tb_mmio_periph_hub;

    localparam logic [31:0] BASE = 32'hf600_0000;
    localparam logic [31:0] A_TX = BASE;
    localparam logic [31:0] A_ST = BASE + 32'd4;
    localparam logic [31:0] A_CL = BASE + 32'd8;
    localparam logic [31:0] A_CH = BASE + 32'd12;
    localparam logic [31:0] A_IL = BASE + 32'd16;
    localparam logic [31:0] A_IH = BASE + 32'd20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic        inst_retire = 1'b0;
    logic [31:0] rdata;
    logic        hit;
    logic        uart_tx;

    mmio_periph_hub #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(4),
        .BAUD_DIV  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .re         (re),
        .inst_retire(inst_retire),
        .rdata      (rdata),
        .hit        (hit),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tick = 0;
    always @(posedge clk) tick <= tick + 1;

    // Reference counts: clocks since reset release, retire pulses since reset release.
    logic [63:0] m_cyc, m_ir;
    always @(posedge clk or posedge rst) begin
        if (rst) m_cyc <= '0;
        else     m_cyc <= m_cyc + 64'd1;
    end
    always @(posedge clk or posedge rst) begin
        if (rst)              m_ir <= '0;
        else if (inst_retire) m_ir <= m_ir + 64'd1;
    end

    logic [7:0]  exp_q[$];
    logic [31:0] bad_addrs [4];
    logic [9:0]  frame;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr = a; re = 1'b1;
        #1;
        chk(tag, rdata, exp);
        chk({tag, "_hit"}, hit, 1);
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string tag);
        bit done;
        done = 1'b0;
        addr = A_ST; re = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk); #1;
            if (rdata[2:0] == 3'b001) done = 1'b1;
        end
        chk(tag, done, 1);
        @(negedge clk);
    endtask

    // UART line monitor: decodes each 8N1 frame by sampling mid-bit.
    initial begin : monitor
        int pos;
        logic [7:0] byte_v;
        logic active;
        active = 1'b0; pos = 0; byte_v = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (uart_tx === 1'b0) begin
                    active = 1'b1;
                    pos = 1;
                end
            end else begin
                if (pos == 2) begin
                    chk("start_bit", uart_tx, 0);
                end else if (pos >= 6 && pos <= 34 && (pos % 4) == 2) begin
                    byte_v[(pos - 6) / 4] = uart_tx;
                end else if (pos == 38) begin
                    chk("stop_bit", uart_tx, 1);
                    chk("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("frame_byte", byte_v, exp_q.pop_front());
                    active = 1'b0;
                end
                pos++;
            end
        end
    end

    initial begin
        int t0;
        logic [7:0] b;
        logic [31:0] hi_exp;
        bit saw_low;

        bad_addrs = '{BASE + 32'd24, BASE + 32'd2, BASE - 32'd4, BASE + 32'd21};

        // Reset state
        repeat (3) @(negedge clk);
        addr = A_ST; #1;
        chk("rst_status", rdata, 32'h1);
        chk("rst_hit", hit, 1);
        chk("rst_tx", uart_tx, 1);
        addr = A_CL; #1;
        chk("rst_cyc_lo", rdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // Instret: 10 pulses in 20 cycles
        for (int i = 0; i < 20; i++) begin
            inst_retire = (i % 2 == 0);
            @(negedge clk);
        end
        inst_retire = 1'b0;
        rd_chk(A_IL, 32'd10, "instret_lo");
        rd_chk(A_IH, 32'd0, "instret_hi");

        // Unmapped / misaligned addresses
        for (int i = 0; i < 4; i++) begin
            addr = bad_addrs[i]; #1;
            chk("unmapped_hit", hit, 0);
            chk("unmapped_rdata", rdata, 0);
        end
        @(negedge clk);

        // Single frame 0x55, exact waveform
        wr(A_TX, 32'h55);
        exp_q.push_back(8'h55);
        frame = {1'b1, 8'h55, 1'b0};
        addr = A_ST; #1;
        chk("t1_pre_status", rdata, 32'h100);
        chk("t1_pre_tx", uart_tx, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            chk("t1_tx", uart_tx, frame[i / 4]);
            chk("t1_busy", rdata[2], 1);
        end
        @(negedge clk); #1;
        chk("t1_post_status", rdata, 32'h1);
        chk("t1_post_tx", uart_tx, 1);
        @(negedge clk);

        // Six back-to-back writes into a depth-4 FIFO
        t0 = tick;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            wr(A_TX, {24'b0, b});
            if (i < 5) exp_q.push_back(b);
        end
        rd_chk(A_ST, 32'h40E, "t2_status_full_ovf");
        while (tick < t0 + 201) @(negedge clk);
        addr = A_ST; #1;
        chk("t2_busy_last_cycle", rdata[2], 1);
        @(negedge clk); #1;
        chk("t2_idle_after_200", rdata, 32'h9);
        chk("t2_frames_drained", exp_q.size(), 0);
        @(negedge clk);
        wr(A_ST, 32'h8);
        rd_chk(A_ST, 32'h1, "t2_ovf_cleared");

        // Push into a full FIFO in the same cycle the FSM pops
        t0 = tick;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            wr(A_TX, {24'b0, b});
            exp_q.push_back(b);
        end
        while (tick < t0 + 41) @(negedge clk);
        b = 8'($urandom_range(0, 255));
        wr(A_TX, {24'b0, b});
        exp_q.push_back(b);
        rd_chk(A_ST, 32'h406, "t3_full_push_pop");
        wait_idle(400, "t3_idle_timeout");
        chk("t3_frames_drained", exp_q.size(), 0);

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: begin
                    for (int i = 0; i < int'($urandom_range(1, 30)); i++) begin
                        inst_retire = 1'($urandom_range(0, 1));
                        @(negedge clk);
                    end
                    inst_retire = 1'b0;
                end
                1: begin
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    hi_exp = m_cyc[63:32];
                    rd_chk(A_CL, m_cyc[31:0], "rnd_cyc_lo");
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    rd_chk(A_CH, hi_exp, "rnd_cyc_hi");
                end
                2: begin
                    hi_exp = m_ir[63:32];
                    rd_chk(A_IL, m_ir[31:0], "rnd_ir_lo");
                    rd_chk(A_IH, hi_exp, "rnd_ir_hi");
                end
                3: begin
                    for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
                        b = 8'($urandom_range(0, 255));
                        wr(A_TX, {24'b0, b});
                        exp_q.push_back(b);
                    end
                    wait_idle(300, "rnd_idle_timeout");
                    chk("rnd_frames_drained", exp_q.size(), 0);
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: wr(A_CL, $urandom);
                        1: wr(A_IH, $urandom);
                        2: wr(BASE + 32'd1, $urandom);
                        default: wr(BASE + 32'd24, $urandom);
                    endcase
                    rd_chk(A_ST, 32'h1, "rnd_ignored_write");
                end
            endcase
        end

        // Cycle counter carry across a LO/HI read pair
        force dut.cyc_cnt = 64'h0000_0000_ffff_fffe;
        addr = A_CL; re = 1'b1; #1;
        chk("carry_lo_pre", rdata, 32'hffff_fffe);
        @(negedge clk);
        re = 1'b0;
        release dut.cyc_cnt;
        repeat (3) @(negedge clk);
        rd_chk(A_CH, 32'd0, "carry_hi_shadow");
        addr = A_CL; re = 1'b1; #1;
        chk("carry_lo_small", rdata < 32'd16, 1);
        @(negedge clk);
        re = 1'b0;
        rd_chk(A_CH, 32'd1, "carry_hi_new");

        // Reset in the middle of a data bit
        wr(A_TX, 32'h00);
        repeat (12) @(negedge clk);
        chk("mid_frame_tx_low", uart_tx, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_tx", uart_tx, 1);
        addr = A_ST; #1;
        chk("rst_mid_status", rdata, 32'h1);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd_chk(A_CL, 32'd0, "post_rst_cyc0");
        repeat (4) @(negedge clk);
        rd_chk(A_CL, 32'd5, "post_rst_cyc5");
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) saw_low = 1'b1;
        end
        chk("post_rst_line_quiet", saw_low, 0);
        rd_chk(A_ST, 32'h1, "post_rst_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
